axi_lite_reg_slave: RTL and testbench
=====================================

# axi_lite_reg_slave

AXI-lite responder terminating the slave side of the AXI-lite 1x1 fabric. It holds a bank of 64-bit registers and accepts AW, W and AR requests. It returns B and R responses with the request ID echoed, and decodes addresses so out-of-range accesses are detected. It sits behind the fabric's s2m port and is the default endpoint for fabric bring-up and verification.

## Interface
- NUM_REGS, 16, number of 64-bit registers (power of two, 2..256)
- aclk  in  1  clock; all logic on rising edge
- arst_n  in  1  reset, asynchronous assert, active-low
- aw_addr  in  64  write byte address
- aw_valid  in  1  write address valid
- aw_id  in  4  write transaction ID
- aw_prot  in  3  protection; accepted, ignored
- aw_ready  out  1  write address accepted
- wdata  in  64  write data
- wvalid  in  1  write data valid
- wstrb  in  9  byte strobes; bit i enables wdata byte i, bit 8 ignored
- wready  out  1  write data accepted
- ar_addr  in  64  read byte address
- ar_valid  in  1  read address valid
- ar_id  in  4  read transaction ID
- ar_prot  in  3  protection; accepted, ignored
- ar_ready  out  1  read address accepted
- rdata  out  64  read data
- rvalid  out  1  read response valid
- rid  out  4  echoed ar_id
- rresp  out  2  00 OKAY, 10 SLVERR
- rready  in  1  read response accepted
- bvalid  out  1  write response valid
- bid  out  4  echoed aw_id
- bresp  out  2  00 OKAY, 10 SLVERR
- bready  in  1  write response accepted

## Operation
- Decode: index = addr[3 +: log2(NUM_REGS)]; addr[2:0] ignored. In range iff addr < NUM_REGS*8.
- Write channel has independent AW and W holding flags.
- aw_ready = !aw_held && !bvalid. AW handshake latches aw_addr and aw_id and sets aw_held.
- wready = !w_held && !bvalid. W handshake latches wdata and wstrb and sets w_held.
- AW and W may arrive in either order or in the same cycle.
- When aw_held && w_held: commit the write, clear both flags, set bvalid, set bid = latched ID.
  - In range: update strobed bytes; bresp = 00. wstrb[7:0] = 0 leaves the register unchanged with bresp = 00.
  - Out of range: no register change; bresp per Configuration.
- bvalid holds, with bid and bresp stable, until bready is sampled high. It clears on that edge.
- Read FSM has two states, R_IDLE and R_RESP.
  - R_IDLE: ar_ready = 1. On AR handshake, capture rdata, rid and rresp; go to R_RESP.
  - R_RESP: ar_ready = 0 and rvalid = 1, with outputs stable. When rready = 1, go to R_IDLE.
- Read data is taken from register state before any write committing in the same cycle, so a simultaneous read returns the old value.
- Read and write paths are fully independent and run concurrently.

## Timing
- Reset (arst_n low, asynchronous):
  - aw_ready, wready, ar_ready, bvalid, rvalid = 0.
  - rdata, rid, rresp, bid, bresp = 0.
  - All registers = 0; holding flags cleared; FSM in R_IDLE.
- First cycle after release: aw_ready = wready = ar_ready = 1.
- Write latency:
  - AW and W in the same cycle N: bvalid high in N+1.
  - Otherwise: bvalid high one cycle after the later of the two handshakes.
- Write throughput: with bready held high, one write every 2 cycles (bvalid in N+1, next AW/W accepted in N+2).
- Read latency: AR handshake in cycle N gives rvalid in N+1. With rready held high, one read every 2 cycles.
- Back-pressure: bready or rready low stalls that channel indefinitely. The other channel continues.
- Reset asserted mid-transaction aborts it. No response is issued after reset.

## Configuration
- AXIL_REG_SLV_ERR_RESP_EN defined:
  - Out-of-range write returns bresp = 10.
  - Out-of-range read returns rresp = 10 with rdata = 0.
- Undefined: out-of-range accesses return OKAY (00). Reads give rdata = 0; writes are silently dropped.
- In-range behaviour is identical in both builds.

## Test plan
- Reset then idle: all outputs 0 during reset. The cycle after release, aw_ready = wready = ar_ready = 1; rdata reads 0 from every register.
- Write addr 0x18, data 0x1122334455667788, wstrb 0x0FF, id 0x5, AW and W same cycle -> bvalid next cycle, bid 5, bresp 00. Read 0x18 -> rdata 0x1122334455667788, rid matches.
- W before AW, then partial strobe: W (data 0xAAAA..AA, wstrb 0x00F) then AW 0x18 three cycles later -> bvalid one cycle after AW. Reg 3 = 0x11223344AAAAAAAA.
- Back-pressure: hold bready low 5 cycles -> bvalid, bid, bresp stable; aw_ready = wready = 0 throughout. A concurrent read completes normally.
- Out of range, addr 0x80 with NUM_REGS = 16: with the macro -> bresp 10 and rresp 10 with rdata 0. Without the macro -> 00, and registers are unchanged.
- Reset mid-transaction: assert arst_n while rvalid is high and rready is low -> rvalid drops immediately, and no response appears after release.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register responder: NUM_REGS x 64-bit registers with strobed writes and a two-state read FSM.
// Optional macro AXIL_REG_SLV_ERR_RESP_EN makes out-of-range accesses return SLVERR instead of OKAY.
module axi_lite_reg_slave #(
  parameter int NUM_REGS = 16
) (
  input  logic        aclk,
  input  logic        arst_n,
  input  logic [63:0] aw_addr,
  input  logic        aw_valid,
  input  logic [3:0]  aw_id,
  input  logic [2:0]  aw_prot,
  output logic        aw_ready,
  input  logic [63:0] wdata,
  input  logic        wvalid,
  input  logic [8:0]  wstrb,
  output logic        wready,
  input  logic [63:0] ar_addr,
  input  logic        ar_valid,
  input  logic [3:0]  ar_id,
  input  logic [2:0]  ar_prot,
  output logic        ar_ready,
  output logic [63:0] rdata,
  output logic        rvalid,
  output logic [3:0]  rid,
  output logic [1:0]  rresp,
  input  logic        rready,
  output logic        bvalid,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  input  logic        bready,
  output logic        r_state_dbg
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [63:0] SPAN = 64'(NUM_REGS) * 64'd8;

`ifdef AXIL_REG_SLV_ERR_RESP_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  // Handshake protocol: a transfer happens on a rising edge where valid and ready are both high;
  // ready/valid outputs are registered and response payloads hold until the matching ready.
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  r_state_e    r_state_q, r_state_d;
  logic [63:0] regs_q [NUM_REGS];
  logic [63:0] regs_d [NUM_REGS];
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [63:0] aw_addr_q, aw_addr_d, wdata_q, wdata_d;
  logic [3:0]  aw_id_q, aw_id_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_ready_q, aw_ready_d, wready_q, wready_d, ar_ready_q, ar_ready_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [3:0]  bid_q, bid_d, rid_q, rid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [63:0] rdata_q, rdata_d;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic        unused_inputs;

  assign unused_inputs = ^{aw_prot, ar_prot, wstrb[8]};
  assign w_idx = aw_addr_d[3 +: IDX_W];
  assign r_idx = ar_addr[3 +: IDX_W];

  always_comb begin
    regs_d     = regs_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    aw_id_d    = aw_id_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    r_state_d  = r_state_q;
    rvalid_d   = rvalid_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;

    if (aw_valid && aw_ready_q) begin
      aw_held_d = 1'b1;
      aw_addr_d = aw_addr;
      aw_id_d   = aw_id;
    end
    if (wvalid && wready_q) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb[7:0];
    end
    if (bvalid_q && bready) bvalid_d = 1'b0;

    // Commit looks at the _d view so AW and W arriving together respond one cycle later.
    if (aw_held_d && w_held_d) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bid_d     = aw_id_d;
      if (aw_addr_d < SPAN) begin
        bresp_d = 2'b00;
        for (int i = 0; i < 8; i++) begin
          if (wstrb_d[i]) regs_d[w_idx][8*i +: 8] = wdata_d[8*i +: 8];
        end
      end else begin
        bresp_d = OOR_RESP;
      end
    end

    case (r_state_q)
      R_IDLE: begin
        if (ar_valid && ar_ready_q) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rid_d     = ar_id;
          if (ar_addr < SPAN) begin
            rdata_d = regs_q[r_idx];
            rresp_d = 2'b00;
          end else begin
            rdata_d = '0;
            rresp_d = OOR_RESP;
          end
        end
      end
      default: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
    endcase

    aw_ready_d = !aw_held_d && !bvalid_d;
    wready_d   = !w_held_d && !bvalid_d;
    ar_ready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
      r_state_q  <= R_IDLE;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      aw_ready_q <= 1'b0;
      wready_q   <= 1'b0;
      ar_ready_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      aw_id_q    <= aw_id_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      aw_ready_q <= aw_ready_d;
      wready_q   <= wready_d;
      ar_ready_q <= ar_ready_d;
    end
  end

  assign aw_ready    = aw_ready_q;
  assign wready      = wready_q;
  assign ar_ready    = ar_ready_q;
  assign bvalid      = bvalid_q;
  assign bid         = bid_q;
  assign bresp       = bresp_q;
  assign rvalid      = rvalid_q;
  assign rid         = rid_q;
  assign rresp       = rresp_q;
  assign rdata       = rdata_q;
  assign r_state_dbg = r_state_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: reset, strobed writes, ordering, back-pressure, range and reset abort.
module tb_axi_lite_reg_slave;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic [63:0] aw_addr, wdata, ar_addr, rdata;
  logic        aw_valid, aw_ready, wvalid, wready, ar_valid, ar_ready;
  logic [3:0]  aw_id, ar_id, rid, bid;
  logic [2:0]  aw_prot, ar_prot;
  logic [8:0]  wstrb;
  logic        rvalid, rready, bvalid, bready, r_state_dbg;
  logic [1:0]  rresp, bresp;

  int checks = 0;
  int failures = 0;

`ifdef AXIL_REG_SLV_ERR_RESP_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  always #5 aclk = ~aclk;

  axi_lite_reg_slave #(.NUM_REGS(16)) dut (
    .aclk(aclk), .arst_n(arst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_id(aw_id), .aw_prot(aw_prot), .aw_ready(aw_ready),
    .wdata(wdata), .wvalid(wvalid), .wstrb(wstrb), .wready(wready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_id(ar_id), .ar_prot(ar_prot), .ar_ready(ar_ready),
    .rdata(rdata), .rvalid(rvalid), .rid(rid), .rresp(rresp), .rready(rready),
    .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
    .r_state_dbg(r_state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the read channel idle again.
  task automatic read_reg(input logic [63:0] addr, input logic [3:0] id,
                          output logic [63:0] data, output logic [1:0] resp);
    int n;
    ar_addr = addr; ar_id = id; ar_valid = 1'b1;
    n = 0;
    while (!ar_ready && n < 20) begin @(negedge aclk); n++; end
    check("ar_ready", ar_ready, 1);
    @(posedge aclk); @(negedge aclk);
    ar_valid = 1'b0;
    check("rvalid", rvalid, 1);
    check("rid", rid, id);
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    rready = 1'b0;
    check("rvalid_clr", rvalid, 0);
  endtask

  task automatic write_same(input logic [63:0] addr, input logic [63:0] data, input logic [8:0] strb,
                            input logic [3:0] id, input bit hold_b, output logic [1:0] resp);
    int n;
    aw_addr = addr; aw_id = id; aw_valid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    n = 0;
    while (!(aw_ready && wready) && n < 20) begin @(negedge aclk); n++; end
    check("aw_w_ready", {aw_ready, wready}, 2'b11);
    @(posedge aclk); @(negedge aclk);
    aw_valid = 1'b0; wvalid = 1'b0;
    check("bvalid", bvalid, 1);
    check("bid", bid, id);
    resp = bresp;
    if (!hold_b) begin
      bready = 1'b1;
      @(posedge aclk); @(negedge aclk);
      bready = 1'b0;
      check("bvalid_clr", bvalid, 0);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    aw_addr = '0; aw_valid = 0; aw_id = '0; aw_prot = '0;
    wdata = '0; wvalid = 0; wstrb = '0;
    ar_addr = '0; ar_valid = 0; ar_id = '0; ar_prot = '0;
    rready = 0; bready = 0;

    repeat (3) @(negedge aclk);
    check("rst_ready", {aw_ready, wready, ar_ready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_rdata", rdata, 0);
    check("rst_ids", {rid, bid}, 8'h00);
    check("rst_resp", {rresp, bresp}, 4'h0);
    arst_n = 1'b1;
    @(negedge aclk);
    check("post_rst_ready", {aw_ready, wready, ar_ready}, 3'b111);

    for (int i = 0; i < 16; i++) begin
      read_reg(64'(i * 8), 4'(i), d, r);
      check("init_rdata", d, 0);
      check("init_rresp", r, 0);
    end

    // Same-cycle AW+W, full strobe
    write_same(64'h18, 64'h1122334455667788, 9'h0FF, 4'h5, 0, r);
    check("wr18_bresp", r, 0);
    read_reg(64'h18, 4'h2, d, r);
    check("rd18", d, 64'h1122334455667788);

    // W three cycles ahead of AW, partial strobe
    wdata = 64'hAAAAAAAAAAAAAAAA; wstrb = 9'h00F; wvalid = 1'b1;
    check("w_first_ready", wready, 1);
    @(posedge aclk); @(negedge aclk);
    wvalid = 1'b0;
    check("w_held_wready", wready, 0);
    check("w_held_aw_ready", aw_ready, 1);
    check("w_held_bvalid0", bvalid, 0);
    repeat (2) begin
      @(negedge aclk);
      check("w_wait_bvalid", bvalid, 0);
    end
    aw_addr = 64'h18; aw_id = 4'h7; aw_valid = 1'b1;
    @(posedge aclk); @(negedge aclk);
    aw_valid = 1'b0;
    check("late_aw_bvalid", bvalid, 1);
    check("late_aw_bid", bid, 4'h7);
    check("late_aw_bresp", bresp, 0);
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    read_reg(64'h18, 4'h3, d, r);
    check("rd18_partial", d, 64'h11223344AAAAAAAA);

    // Back-pressure on B with a read running alongside
    write_same(64'h28, 64'h0123456789ABCDEF, 9'h1FF, 4'hA, 1, r);
    read_reg(64'h18, 4'h9, d, r);
    check("bp_concurrent_rd", d, 64'h11223344AAAAAAAA);
    repeat (5) begin
      @(negedge aclk);
      check("bp_bvalid", bvalid, 1);
      check("bp_bid", bid, 4'hA);
      check("bp_bresp", bresp, 0);
      check("bp_ready", {aw_ready, wready}, 2'b00);
    end
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    check("bp_release", bvalid, 0);
    read_reg(64'h28, 4'h1, d, r);
    check("rd28", d, 64'h0123456789ABCDEF);

    // Zero strobe leaves the register alone
    write_same(64'h28, 64'hFFFFFFFFFFFFFFFF, 9'h100, 4'h1, 0, r);
    check("zero_strb_bresp", r, 0);
    read_reg(64'h2C, 4'h4, d, r);
    check("zero_strb_rd", d, 64'h0123456789ABCDEF);

    // Out of range must not alias onto register 0
    write_same(64'h80, 64'hDEADBEEFCAFEF00D, 9'h0FF, 4'h3, 0, r);
    check("oor_bresp", r, OOR_RESP);
    read_reg(64'h80, 4'h6, d, r);
    check("oor_rdata", d, 0);
    check("oor_rresp", r, OOR_RESP);
    read_reg(64'h00, 4'h6, d, r);
    check("oor_no_alias", d, 0);

    write_same(64'h78, 64'h0F0E0D0C0B0A0908, 9'h0FF, 4'hF, 0, r);
    check("wr78_bresp", r, 0);

    // Read and write of the same register in one cycle: read sees the old value
    ar_addr = 64'h78; ar_id = 4'hC; ar_valid = 1'b1;
    aw_addr = 64'h78; aw_id = 4'hD; aw_valid = 1'b1;
    wdata = 64'h5555666677778888; wstrb = 9'h0FF; wvalid = 1'b1;
    check("sim_ready", {ar_ready, aw_ready, wready}, 3'b111);
    @(posedge aclk); @(negedge aclk);
    ar_valid = 1'b0; aw_valid = 1'b0; wvalid = 1'b0;
    check("sim_valids", {rvalid, bvalid}, 2'b11);
    check("sim_old_rdata", rdata, 64'h0F0E0D0C0B0A0908);
    rready = 1'b1; bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    rready = 1'b0; bready = 1'b0;
    read_reg(64'h78, 4'h0, d, r);
    check("sim_new_rdata", d, 64'h5555666677778888);

    // Reset while a read response is stalled
    ar_addr = 64'h18; ar_id = 4'hE; ar_valid = 1'b1;
    @(posedge aclk); @(negedge aclk);
    ar_valid = 1'b0;
    check("abort_rvalid_pre", rvalid, 1);
    #2 arst_n = 1'b0;
    #1;
    check("abort_rvalid_drop", rvalid, 0);
    check("abort_ar_ready", ar_ready, 0);
    @(negedge aclk);
    arst_n = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("abort_no_resp", {rvalid, bvalid}, 2'b00);
    end
    read_reg(64'h18, 4'h2, d, r);
    check("abort_regs_cleared", d, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
